// File: rtl/teclado_scanner.sv
// rtl/teclado_scanner.sv - 4x4 keypad scanner with debounce and one-shot key events
//
// Purpose: drives the keypad columns one at a time, synchronizes the rows,
// debounces both press and release, and turns each accepted key into a single
// one-cycle push (digit on entrada) or guardar (# key) pulse.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   filas     raw keypad rows, asynchronous, active-low
//   columnas  column drive, active-low, one bit low at a time
//   entrada   last accepted digit, held until the next digit
//   push      one-cycle pulse, digit accepted (entrada valid same cycle)
//   guardar   one-cycle pulse, # key accepted
module teclado_scanner #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] entrada,
   output logic       push,
   output logic       guardar
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] CNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_EMIT,
      S_RELEASE
   } state_t;

   state_t        state;
   logic [3:0]    filas_m;
   logic [3:0]    filas_s;
   logic [3:0]    patron;
   logic [SW-1:0] slot;
   logic [DW-1:0] cnt;

   logic [1:0]    col;
   logic [1:0]    row;
   logic          is_digit;
   logic          is_hash;
   logic [3:0]    digito;

   // Column index of the currently driven (low) column.
   always_comb begin
      col = 2'd0;
      case (columnas)
         4'b1101: col = 2'd1;
         4'b1011: col = 2'd2;
         4'b0111: col = 2'd3;
         default: col = 2'd0;
      endcase
   end

   // Lowest low row wins when several keys in one column are pressed.
   always_comb begin
      if (!patron[0])      row = 2'd0;
      else if (!patron[1]) row = 2'd1;
      else if (!patron[2]) row = 2'd2;
      else                 row = 2'd3;
   end

   // Rows 0..2 / columns 0..2 hold digits 1..9 laid out as r*3+c+1;
   // row 3 carries * 0 # and column 3 the letter keys.
   always_comb begin
      is_digit = 1'b0;
      is_hash  = 1'b0;
      digito   = 4'd0;
      if (row != 2'd3) begin
         if (col != 2'd3) begin
            is_digit = 1'b1;
            digito   = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
         end
      end else if (col == 2'd1) begin
         is_digit = 1'b1;
         digito   = 4'd0;
      end else if (col == 2'd2) begin
         is_hash = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_SCAN;
         filas_m  <= 4'hF;
         filas_s  <= 4'hF;
         patron   <= 4'hF;
         slot     <= '0;
         cnt      <= '0;
         columnas <= 4'b1110;
         entrada  <= 4'd0;
         push     <= 1'b0;
         guardar  <= 1'b0;
      end else begin
         filas_m <= filas;
         filas_s <= filas_m;
         push    <= 1'b0;
         guardar <= 1'b0;

         case (state)
            S_SCAN: begin
               if (slot == SLOT_LAST) begin
                  slot <= '0;
                  if (filas_s != 4'hF) begin
                     // Column stays frozen while the press is qualified.
                     patron <= filas_s;
                     cnt    <= '0;
                     state  <= S_DEBOUNCE;
                  end else begin
                     columnas <= {columnas[2:0], columnas[3]};
                  end
               end else begin
                  slot <= slot + 1'b1;
               end
            end

            S_DEBOUNCE: begin
               if (filas_s != patron) begin
                  slot  <= '0;
                  state <= S_SCAN;
               end else if (cnt == CNT_LAST) begin
                  state <= S_EMIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_EMIT: begin
               push    <= is_digit;
               guardar <= is_hash;
               if (is_digit) entrada <= digito;
               cnt   <= '0;
               state <= S_RELEASE;
            end

            S_RELEASE: begin
               // Any low row restarts the release qualification, so a held
               // key never produces a second event.
               if (filas_s != 4'hF) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt      <= '0;
                  slot     <= '0;
                  columnas <= {columnas[2:0], columnas[3]};
                  state    <= S_SCAN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= S_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_teclado_scanner.sv
// tb/tb_teclado_scanner.sv - scoreboard bench for teclado_scanner
module tb_teclado_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] filas;
   logic [3:0] columnas;
   logic [3:0] entrada;
   logic       push;
   logic       guardar;

   logic [15:0] key_down = '0;
   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit         save;
      logic [3:0] val;
      int         at;
   } ev_t;

   ev_t sb[$];
   ev_t mon_e;

   teclado_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .filas    (filas),
      .columnas (columnas),
      .entrada  (entrada),
      .push     (push),
      .guardar  (guardar)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Keypad model: key at (r,c) pulls row r low while column c is driven.
   always_comb begin
      filas = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_down[r*4+c] && !columnas[c]) filas[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (push || guardar) begin
         if (push && guardar) begin
            n_cmp++; n_bad++;
            $display("FAIL both_pulses push=%b guardar=%b required only one", push, guardar);
         end else if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event cyc=%0d push=%b guardar=%b entrada=%0d required no event",
                     cyc, push, guardar, entrada);
         end else begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (guardar != mon_e.save) begin
               n_bad++;
               $display("FAIL event_kind guardar=%b required guardar=%b", guardar, mon_e.save);
            end
            n_cmp++;
            if (entrada !== mon_e.val) begin
               n_bad++;
               $display("FAIL event_entrada got=%0d required=%0d", entrada, mon_e.val);
            end
            if (mon_e.at >= 0) begin
               n_cmp++;
               if (cyc != mon_e.at) begin
                  n_bad++;
                  $display("FAIL event_latency cyc=%0d required=%0d", cyc, mon_e.at);
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns the cycle number of the last edge that saw reset high.
   task automatic do_reset(input int n, output int r);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      r = cyc;
   endtask

   task automatic press(input int idx, input int hold, input int gap);
      key_down[idx] = 1'b1;
      tick(hold);
      key_down[idx] = 1'b0;
      tick(gap);
   endtask

   int R;
   int R2;

   initial begin
      // Reset values and idle column rotation.
      do_reset(3, R);
      check("rst_columnas", int'(columnas), 4'b1110);
      check("rst_entrada", int'(entrada), 0);
      check("rst_push", int'(push), 0);
      check("rst_guardar", int'(guardar), 0);
      tick(3);
      check("col_hold_slot", int'(columnas), 4'b1110);
      tick(1);
      check("col_rot1", int'(columnas), 4'b1101);
      tick(4);
      check("col_rot2", int'(columnas), 4'b1011);
      tick(4);
      check("col_rot3", int'(columnas), 4'b0111);
      tick(4);
      check("col_wrap", int'(columnas), 4'b1110);

      // Digits 3, 5, 7 then # (entrada keeps 7).
      sb.push_back('{save: 1'b0, val: 4'd3, at: -1});
      press(2, 40, 30);
      sb.push_back('{save: 1'b0, val: 4'd5, at: -1});
      press(5, 40, 30);
      sb.push_back('{save: 1'b0, val: 4'd7, at: -1});
      press(8, 40, 30);
      sb.push_back('{save: 1'b1, val: 4'd7, at: -1});
      press(14, 40, 30);

      // Bounce on key 4 (r1,c0): no event expected.
      repeat (5) begin
         key_down[4] = 1'b1;
         tick(3);
         key_down[4] = 1'b0;
         tick(2);
      end
      tick(30);

      // Steady key 4 from a known scan phase: slot-end sample at R+4.
      key_down[4] = 1'b1;
      do_reset(3, R);
      sb.push_back('{save: 1'b0, val: 4'd4, at: R + SCAN_DIV + DEB + 1});
      tick(40);
      key_down[4] = 1'b0;
      tick(30);

      // Long hold of 9 gives one push; A and D give nothing.
      sb.push_back('{save: 1'b0, val: 4'd9, at: -1});
      press(10, 200, 30);
      press(3, 40, 30);
      press(15, 40, 30);

      // Key 1 in c0; reset lands 4 cycles into debounce.
      key_down[0] = 1'b1;
      do_reset(3, R);
      tick(7);
      rst = 1'b1;
      tick(1);
      check("mid_rst_columnas", int'(columnas), 4'b1110);
      check("mid_rst_entrada", int'(entrada), 0);
      check("mid_rst_push", int'(push), 0);
      check("mid_rst_guardar", int'(guardar), 0);
      tick(1);
      rst = 1'b0;
      R2 = cyc;
      sb.push_back('{save: 1'b0, val: 4'd1, at: R2 + SCAN_DIV + DEB + 1});
      tick(40);
      key_down[0] = 1'b0;
      tick(30);

      check("pending_events", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
